// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32 datapath (lw/sw/R/I/branch/jal).
// Define MC_CTRL_MEM_HANDSHAKE_EN to stall FETCH and MEMREAD on mem_ready.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       funct3_0,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e state_q, state_d;
  logic   mem_ok;
  logic   legal_op;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    legal_op = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R,
      OP_I, OP_BR, OP_JAL: legal_op = 1'b1;
      default:             legal_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (mem_ok) state_d = S_DECODE;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      S_MEMADR:
        state_d = (op == OP_SW) ? S_MEMWRITE
                                : S_MEMREAD;
      S_MEMREAD:
        if (mem_ok) state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:
        state_d = S_ALUWB;
      default:
        state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset overrides the state decode so outputs never follow a stale state.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    if (reset) begin
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state_q)
        S_FETCH: begin
          IRWrite   = mem_ok;
          PCWrite   = mem_ok;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b01;
          instr_done = ~legal_op;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUOp      = 2'b01;
          PCWrite    = zero ^ funct3_0;
          instr_done = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction state sequences predict every cycle.
// Directed lw/sw/branch/illegal/reset/stall cases, then random traffic.
module tb_multicycle_controller;

`ifdef MC_CTRL_MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;

  typedef struct packed {
    logic       pcw;
    logic       adrs;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] imm;
    logic       done;
    logic [3:0] st;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic       funct3_0 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       instr_done;
  logic [3:0] state_o;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op),
    .funct3_0(funct3_0), .zero(zero),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .state_o(state_o)
  );

  out_t       exp_q[$];
  logic [6:0] forced[$];
  int         seq[$];
  int         idx = 0;
  int         retired = 0;
  logic [6:0] cur_op = '0;
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == LW || o == SW || o == RT ||
           o == IT || o == BR || o == JL;
  endfunction

  function automatic out_t model(input int s, input logic [6:0] o,
                                 input logic z, input logic f3,
                                 input logic mr, input logic rst);
    out_t e = '0;
    e.imm = imm_of(o);
    if (rst) begin
      e.srcb = 2'b10;
      e.res  = 2'b10;
      return e;
    end
    e.st = 4'(s);
    case (s)
      0: begin
        e.irw = !(HS && !mr);
        e.pcw = !(HS && !mr);
        e.srcb = 2'b10; e.res = 2'b10;
      end
      1: begin
        e.srca = 2'b01; e.srcb = 2'b01;
        e.done = !legal(o);
      end
      2: begin e.srca = 2'b10; e.srcb = 2'b01; end
      3: e.adrs = 1'b1;
      4: begin e.res = 2'b01; e.regw = 1; e.done = 1; end
      5: begin e.adrs = 1; e.memw = 1; e.done = 1; end
      6: begin e.srca = 2'b10; e.aluop = 2'b10; end
      7: begin
        e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10;
      end
      8: begin e.regw = 1; e.done = 1; end
      9: begin
        e.srca = 2'b10; e.aluop = 2'b01;
        e.pcw = z ^ f3; e.done = 1;
      end
      10: begin
        e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 7))
      0: return LW;
      1: return SW;
      2: return RT;
      3: return IT;
      4: return BR;
      5: return JL;
      6: return ILL;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic int cur_state();
    return seq[idx];
  endfunction

  task automatic new_instr();
    idx = 0;
    retired++;
    if (forced.size() != 0) cur_op = forced.pop_front();
    else cur_op = rand_op();
    if (cur_op == LW)      seq = {0, 1, 2, 3, 4};
    else if (cur_op == SW) seq = {0, 1, 2, 5};
    else if (cur_op == RT) seq = {0, 1, 6, 8};
    else if (cur_op == IT) seq = {0, 1, 7, 8};
    else if (cur_op == BR) seq = {0, 1, 9};
    else if (cur_op == JL) seq = {0, 1, 10, 8};
    else                   seq = {0, 1};
  endtask

  task automatic step(input logic rst, input logic z,
                      input logic f3, input logic mr);
    bit hold;
    reset = rst; zero = z; funct3_0 = f3;
    mem_ready = mr; op = cur_op;
    exp_q.push_back(model(cur_state(), cur_op, z, f3, mr, rst));
    hold = HS && !mr && (cur_state() == 0 || cur_state() == 3);
    @(posedge clk); #1;
    cyc++;
    if (rst) idx = 0;
    else if (!hold) begin
      idx++;
      if (idx >= seq.size()) new_instr();
    end
  endtask

  task automatic run_instr(input logic z, input logic f3);
    int start = retired;
    int n = 0;
    while (retired == start && n < 20) begin
      step(1'b0, z, f3, 1'b1);
      n++;
    end
    if (retired == start) begin
      checks++;
      $display("FAIL run_instr timeout op=%b", cur_op);
    end
  endtask

  task automatic run_to(input int s);
    int n = 0;
    while (cur_state() != s && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    if (cur_state() != s) begin
      checks++;
      $display("FAIL run_to timeout state=%0d want=%0d",
               cur_state(), s);
    end
  endtask

  always @(negedge clk) begin
    out_t got, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
             instr_done, state_o};
      checks++;
      if (got === e) passed++;
      else $display("FAIL ctrl cyc=%0d op=%b rst=%b got=%h exp=%h",
                    cyc, op, reset, got, e);
    end
  end

  initial begin
    forced = {LW, SW, BR, BR, ILL, JL, RT, IT, LW, LW, SW};
    new_instr();
    @(posedge clk); #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    run_instr(1'b1, 1'b0);
    run_instr(1'b0, 1'b0);
    run_instr(1'b1, 1'b0);
    run_instr(1'b1, 1'b1);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    run_to(3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_instr(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_to(3);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic r, mr;
      r = ($urandom_range(0, 49) == 0);
      mr = HS ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      step(r, 1'($urandom), 1'($urandom), mr);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain left=%0d", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have port op, input, 7 bits: opcode of the instruction register.
REQ-004 SHALL have port funct3_0, input, 1 bit: funct3[0], where 0 selects beq and 1 selects bne.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory handshake, used only under the macro in REQ-024.
REQ-007 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, each 1 bit.
REQ-008 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc, each 2 bits.
REQ-009 SHALL have output instr_done, 1 bit: pulses once per retired instruction.
REQ-010 SHALL have output state_o, 4 bits: current state encoding, for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 SHALL go to FETCH.
REQ-012 SHALL transition as follows:
- FETCH->DECODE.
- DECODE: op 0000011 or 0100011 ->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; any other op->FETCH.
- MEMADR: lw->MEMREAD, sw->MEMWRITE.
- MEMREAD->MEMWB.
- EXECR, EXECI and JAL ->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH ->FETCH.
REQ-013 SHALL give these cycle counts, FETCH inclusive: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4, illegal 2.
REQ-014 In FETCH, outputs SHALL be: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1.
REQ-015 In DECODE, outputs SHALL be: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computation).
REQ-016 In MEMADR, outputs SHALL be: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-017 In MEMREAD, outputs SHALL be: ResultSrc=00, AdrSrc=1.
REQ-018 In MEMWB, outputs SHALL be: ResultSrc=01, RegWrite=1.
REQ-019 In MEMWRITE, outputs SHALL be: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-020 SHALL drive these outputs in the remaining states:
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero^funct3_0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
REQ-021 Any output not listed for a state SHALL be 0. No output SHALL ever be X.
REQ-022 ImmSrc SHALL be decoded combinationally from op in every state: I-type/load 00, store 01, branch 10, jal 11, otherwise 00.
REQ-023 instr_done SHALL be 1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and in DECODE for an illegal op; otherwise 0.

Configuration
REQ-024 With MC_CTRL_MEM_HANDSHAKE_EN defined, the FSM SHALL hold in FETCH and in MEMREAD while mem_ready=0. While holding, IRWrite, PCWrite and instr_done SHALL be 0, and they SHALL assert only in the cycle where mem_ready=1.
REQ-025 Without MC_CTRL_MEM_HANDSHAKE_EN, mem_ready SHALL be ignored and REQ-013 timing is exact.

Reset
REQ-026 reset=1 at a clock edge SHALL force the state to FETCH, from any state including mid-instruction.
REQ-027 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and instr_done SHALL be 0.
REQ-028 While reset=1, all other outputs SHALL take their FETCH values.
REQ-029 The first cycle after reset deasserts SHALL be a normal FETCH.

Verification
REQ-030 Bench SHALL cover a lw sequence: op=0000011 -> state_o 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-031 Bench SHALL cover a sw sequence: op=0100011 -> states 0,1,2,5; MemWrite=1 exactly one cycle, with AdrSrc=1 and ImmSrc=01.
REQ-032 Bench SHALL cover beq with zero=1 and bne with zero=1: in BRANCH, PCWrite=1 for beq and 0 for bne; both return to FETCH after 3 cycles.
REQ-033 Bench SHALL cover an illegal op: op=1111111 -> states 0,1,0; no write enables in DECODE; instr_done=1 in DECODE.
REQ-034 Bench SHALL cover reset asserted in MEMREAD: next state FETCH, with RegWrite and PCWrite 0 throughout reset.
REQ-035 Bench SHALL cover the handshake with the macro defined: mem_ready=0 for 3 cycles in FETCH -> state_o stays 0 and IRWrite stays 0; IRWrite=1 and PCWrite=1 only on the mem_ready=1 cycle.
